// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one broadcast slot per cycle shared by 4 FU result ports.
// Optional build macro CDB_PRIO0_EN gives FU 0 absolute priority over a 3-way rotation of FUs 1-3.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*TAG_W-1:0]  req_tag,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic                cdb_hold,
  output logic [3:0]          gnt,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [1:0]          cdb_sel
);

  logic [1:0]        ptr_r;
  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_data_r;
  logic [1:0]        cdb_sel_r;

  logic              found_s;
  logic              hit_s;
  logic [1:0]        cand_s;
  logic [1:0]        win_s;
  logic [3:0]        gnt_s;

  // Winner search: first requester at or after ptr (mod 4); grant suppressed in reset or on hold.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = 2'd0;
    win_s   = 2'd0;
    gnt_s   = 4'b0000;
    if (rst_n && !cdb_hold) begin
`ifdef CDB_PRIO0_EN
      if (req[0]) begin
        found_s = 1'b1;
        win_s   = 2'd0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          cand_s  = ptr_r + 2'(k);
          hit_s   = req[cand_s] && (cand_s != 2'd0) && !found_s;
          win_s   = hit_s ? cand_s : win_s;
          found_s = found_s | hit_s;
        end
      end
`else
      for (int k = 0; k < 4; k++) begin
        cand_s  = ptr_r + 2'(k);
        hit_s   = req[cand_s] && !found_s;
        win_s   = hit_s ? cand_s : win_s;
        found_s = found_s | hit_s;
      end
`endif
    end else begin
      found_s = 1'b0;
    end
    if (found_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = 4'b0000;
    end
  end

  assign gnt = gnt_s;

  // Broadcast register and rotation pointer; tag/data/sel hold when no transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= 2'd0;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= '0;
      cdb_data_r  <= '0;
      cdb_sel_r   <= 2'd0;
    end else if (found_s) begin
      cdb_valid_r <= 1'b1;
      cdb_tag_r   <= req_tag[int'(win_s)*TAG_W +: TAG_W];
      cdb_data_r  <= req_data[int'(win_s)*DATA_W +: DATA_W];
      cdb_sel_r   <= win_s;
`ifdef CDB_PRIO0_EN
      // FU 0 wins outside the rotation, so its transfers leave the pointer alone.
      if (win_s != 2'd0) begin
        ptr_r <= win_s + 2'd1;
      end else begin
        ptr_r <= ptr_r;
      end
`else
      ptr_r <= win_s + 2'd1;
`endif
    end else begin
      cdb_valid_r <= 1'b0;
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_tag   = cdb_tag_r;
  assign cdb_data  = cdb_data_r;
  assign cdb_sel   = cdb_sel_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table with literal grants, then randomized handshake
// traffic compared every cycle against a queue-free arithmetic model (honours CDB_PRIO0_EN).
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          req;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic                cdb_hold;
  logic [3:0]          gnt;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_sel;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_tag(req_tag), .req_data(req_data),
    .cdb_hold(cdb_hold), .gnt(gnt), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_sel(cdb_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: index of the winner (-1 for none) from the arbitration rules.
  function automatic int model_winner(input logic [3:0] r, input logic h, input int p);
    if (h || r == 4'b0000) return -1;
`ifdef CDB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
`ifdef CDB_PRIO0_EN
      if (i == 0) continue;
`endif
      if (r[i]) return i;
    end
    return -1;
  endfunction

  int              mptr;
  logic            mvalid;
  logic [TAG_W-1:0]  mtag;
  logic [DATA_W-1:0] mdata;
  logic [1:0]      msel;
  int              mwin;

  assign mwin = model_winner(req, cdb_hold, mptr);

  // Model state: what the CDB must show one cycle after each transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mptr <= 0; mvalid <= 1'b0; mtag <= '0; mdata <= '0; msel <= 2'd0;
    end else if (mwin < 0) begin
      mvalid <= 1'b0;
    end else begin
      mvalid <= 1'b1;
      mtag   <= req_tag[mwin*TAG_W +: TAG_W];
      mdata  <= req_data[mwin*DATA_W +: DATA_W];
      msel   <= 2'(mwin);
`ifdef CDB_PRIO0_EN
      if (mwin != 0) mptr <= (mwin + 1) % 4;
`else
      mptr <= (mwin + 1) % 4;
`endif
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_gnt", 64'(gnt), (mwin < 0) ? 64'd0 : (64'd1 << mwin));
      check("cmp_onehot", 64'($onehot0(gnt)), 64'd1);
      check("cmp_valid", 64'(cdb_valid), 64'(mvalid));
      check("cmp_tag", 64'(cdb_tag), 64'(mtag));
      check("cmp_data", 64'(cdb_data), 64'(mdata));
      check("cmp_sel", 64'(cdb_sel), 64'(msel));
    end else begin
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_out", {27'd0, cdb_valid, cdb_tag, cdb_data}, 64'd0);
      check("rst_sel", 64'(cdb_sel), 64'd0);
    end
  end

  logic [3:0] sreq  [18];
  logic [3:0] sgnt  [18];
  logic [17:0] shold = 18'b00_0000_0011_0000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int c);
    logic [TAG_W-1:0]  wtag;
    logic [DATA_W-1:0] wdata;
    int w;
    req = sreq[c];
    cdb_hold = shold[c];
    #2;
    check($sformatf("dir_gnt_c%0d", c), 64'(gnt), 64'(sgnt[c]));
    w = 0;
    for (int i = 0; i < 4; i++) if (sgnt[c][i]) w = i;
    wtag  = req_tag[w*TAG_W +: TAG_W];
    wdata = req_data[w*DATA_W +: DATA_W];
    tick();
    check($sformatf("dir_valid_c%0d", c), 64'(cdb_valid), 64'(sgnt[c] != 4'b0000));
    if (sgnt[c] != 4'b0000) begin
      check($sformatf("dir_sel_c%0d", c), 64'(cdb_sel), 64'(w));
      check($sformatf("dir_tag_c%0d", c), 64'(cdb_tag), 64'(wtag));
      check($sformatf("dir_data_c%0d", c), 64'(cdb_data), 64'(wdata));
    end
  endtask

  logic [3:0] g;

  initial begin
    sreq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h4, 4'h0, 4'h9, 4'h3,
             4'h3, 4'h3, 4'h2, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE};
`ifdef CDB_PRIO0_EN
    sgnt = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h0, 4'h1, 4'h0,
             4'h0, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h4, 4'h8, 4'h2};
`else
    sgnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h0, 4'h8, 4'h0,
             4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
`endif
    rst_n = 1'b0;
    req = 4'b1111;
    cdb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = 4'(i + 1);
      req_data[i*DATA_W +: DATA_W] = 32'h1000_0000 + 32'(i);
    end
    #7;
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_valid", 64'(cdb_valid), 64'd0);
    check("reset_tag_data_sel", {26'd0, cdb_tag, cdb_data, cdb_sel}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 5) begin
        req_tag[2*TAG_W +: TAG_W]    = 4'hA;
        req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
      end
      step(c);
      if (c == 5) begin
        check("single_tag", 64'(cdb_tag), 64'hA);
        check("single_data", 64'(cdb_data), 64'hDEADBEEF);
        check("single_sel", 64'(cdb_sel), 64'd2);
      end
      if (c == 6) begin
        check("idle_hold_tag", 64'(cdb_tag), 64'hA);
        check("idle_hold_data", 64'(cdb_data), 64'hDEADBEEF);
        check("idle_hold_sel", 64'(cdb_sel), 64'd2);
      end
    end
    // Async reset mid-broadcast: outputs must clear before any clock edge.
    check("pre_async_valid", 64'(cdb_valid), 64'd1);
    req = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(cdb_valid), 64'd0);
    check("async_tag_data_sel", {26'd0, cdb_tag, cdb_data, cdb_sel}, 64'd0);
    check("async_gnt", 64'(gnt), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    g = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      rst_n = (n != 1500);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || g[i]) begin
          req[i] = ($urandom_range(3, 0) != 0);
          req_tag[i*TAG_W +: TAG_W]    = 4'($urandom);
          req_data[i*DATA_W +: DATA_W] = $urandom;
        end else if ($urandom_range(15, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      cdb_hold = ($urandom_range(4, 0) == 0);
      #2 g = gnt;
      tick();
    end
    rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
